// File: rtl/scan_pkg.sv
// rtl/scan_pkg.sv - shared constants and helpers for the display scan controller
package scan_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int NIBBLE_W   = 4;
  localparam int SEL_W      = 2;
  localparam int DISP_W     = NUM_DIGITS * NIBBLE_W;

  // All anodes off (anodes are active-low)
  localparam logic [NUM_DIGITS-1:0] AN_OFF = 4'b1111;

  // Index of the last digit in a frame; a digit tick here closes the frame
  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NUM_DIGITS - 1);

  // One-hot-low anode pattern for a digit index
  function automatic logic [NUM_DIGITS-1:0] an_onehot_low(input logic [SEL_W-1:0] s);
    logic [NUM_DIGITS-1:0] w_onehot;
    w_onehot = NUM_DIGITS'(1) << s;
    return ~w_onehot;
  endfunction

endpackage

// File: rtl/scan_ctrl_tick_gen.sv
// rtl/scan_ctrl_tick_gen.sv - digit-period prescaler producing a one-cycle tick
module tick_gen #(
  parameter int DIV_MAX   = 99999,
  parameter int DIV_WIDTH = 17
) (
  input  logic clk,
  input  logic resetn,
  input  logic en,
  output logic tick
);

  logic [DIV_WIDTH-1:0] r_cnt;
  logic                 w_at_max;

  assign w_at_max = (r_cnt == DIV_WIDTH'(DIV_MAX));

  // Tick is derived from registered count so it lines up with the edge that wraps it
  assign tick = resetn & en & w_at_max;

  // Free-running divider that wraps at DIV_MAX and freezes while scanning is disabled
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cnt <= '0;
    end else if (en) begin
      if (w_at_max) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + DIV_WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/scan_ctrl.sv
// rtl/scan_ctrl.sv - multiplexed 4-digit display scanner with tear-free value commit
module scan_ctrl
  import scan_pkg::*;
#(
  parameter int DIV_MAX   = 99999,
  parameter int DIV_WIDTH = 17
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  en,
  input  logic                  load,
  input  logic [DISP_W-1:0]     din,
  input  logic                  blank_lz,
  output logic [DISP_W-1:0]     disp_val,
  output logic [SEL_W-1:0]      sel,
  output logic [NUM_DIGITS-1:0] an,
  output logic                  pending,
  output logic                  frame_tick
);

  logic                  w_tick;
  logic                  w_frame;
  logic [SEL_W-1:0]      r_sel;
  logic [DISP_W-1:0]     r_disp;
  logic [DISP_W-1:0]     r_shadow;
  logic                  r_pending;
  logic [NUM_DIGITS-1:0] w_nib_zero;
  logic [NUM_DIGITS-1:0] w_blank;
  logic                  w_tail_zero;
  logic [NUM_DIGITS-1:0] w_an;

  tick_gen #(
    .DIV_MAX   (DIV_MAX),
    .DIV_WIDTH (DIV_WIDTH)
  ) u_tick_gen (
    .clk    (clk),
    .resetn (resetn),
    .en     (en),
    .tick   (w_tick)
  );

  // The frame closes on the digit tick that leaves the last digit
  assign w_frame = w_tick & (r_sel == SEL_LAST);

  // Digit index advances once per digit period and wraps after the last digit
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_sel <= '0;
    end else if (w_tick) begin
      r_sel <= r_sel + SEL_W'(1);
    end
  end

  // Stage loads in the shadow and only move them to the display word at a frame boundary;
  // a load landing on the boundary itself goes straight to the display
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_disp    <= '0;
      r_shadow  <= '0;
      r_pending <= 1'b0;
    end else if (w_frame) begin
      if (load) begin
        r_disp <= din;
      end else if (r_pending) begin
        r_disp <= r_shadow;
      end
      r_pending <= 1'b0;
    end else if (load) begin
      r_shadow  <= din;
      r_pending <= 1'b1;
    end
  end

  // Leading-zero blanking: digit k is dark when it and every higher nibble are zero
  always_comb begin
    w_blank     = '0;
    w_tail_zero = 1'b1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      w_nib_zero[k] = (r_disp[k*NIBBLE_W +: NIBBLE_W] == '0);
    end
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      w_tail_zero = w_tail_zero & w_nib_zero[k];
      w_blank[k]  = blank_lz & w_tail_zero;
    end
  end

  // Anode decode straight from the registered index so an and sel never skew
  always_comb begin
    w_an = AN_OFF;
    if (resetn && en && !w_blank[r_sel]) begin
      w_an = an_onehot_low(r_sel);
    end
  end

  assign sel        = r_sel;
  assign an         = w_an;
  assign disp_val   = r_disp;
  assign pending    = r_pending;
  assign frame_tick = w_frame;

endmodule

// File: doc/scan_ctrl.md
SCAN_CTRL -- requirements
Module: scan_ctrl

Interface
REQ-001 The block SHALL have parameter DIV_MAX, default 99999, giving the prescaler terminal count (digit period = DIV_MAX+1 clocks).
REQ-002 The block SHALL have parameter DIV_WIDTH, default 17, giving the prescaler counter width, which must be at least clog2(DIV_MAX+1).
REQ-003 The block SHALL have port clk, input, 1 bit: the single system clock; all state changes on its rising edge.
REQ-004 The block SHALL have port resetn, input, 1 bit: reset, asynchronous, active-low.
REQ-005 The block SHALL have port en, input, 1 bit: scan enable; 0 freezes the scan and blanks the display.
REQ-006 The block SHALL have port load, input, 1 bit: single-cycle request to stage din.
REQ-007 The block SHALL have port din, input, 16 bits: four packed BCD/hex nibbles, with digit 0 = din[3:0].
REQ-008 The block SHALL have port blank_lz, input, 1 bit: enables leading-zero blanking.
REQ-009 The block SHALL have port disp_val, output, 16 bits: the committed display word, which feeds the downstream 4:1 nibble mux data input.
REQ-010 The block SHALL have port sel, output, 2 bits: the current digit index, which feeds the downstream mux select.
REQ-011 The block SHALL have port an, output, 4 bits: active-low anode enables, one-hot-low for the current digit.
REQ-012 The block SHALL have port pending, output, 1 bit: staged value awaiting commit.
REQ-013 The block SHALL have port frame_tick, output, 1 bit: one-cycle pulse at each frame boundary.

Function
REQ-014 div_cnt SHALL increment by 1 each clock while en=1, wrap from DIV_MAX to 0, and hold while en=0.
REQ-015 A digit tick SHALL occur in the cycle where en=1 and div_cnt==DIV_MAX; on that edge sel SHALL advance 00->01->10->11->00.
REQ-016 A frame boundary SHALL be a digit tick while sel==11; frame_tick SHALL be 1 in exactly that cycle, combinational from registered state.
REQ-017 load=1 with no frame boundary SHALL write din to the shadow register and set pending=1 on the same edge.
REQ-018 load=1 while pending=1 SHALL overwrite the shadow register, so the last writer wins and no error is flagged.
REQ-019 At a frame boundary with pending=1 and load=0, disp_val SHALL take the shadow value and pending SHALL clear on that edge.
REQ-020 At a frame boundary with load=1, disp_val SHALL take din directly and pending SHALL clear, with the shadow bypassed.
REQ-021 disp_val SHALL change only at frame boundaries, so that no frame mixes old and new digits (tear-free).
REQ-022 Digit k (k=1..3) SHALL be blanked when blank_lz=1 and nibbles k..3 of disp_val are all zero; digit 0 SHALL never be blanked.
REQ-023 an SHALL be 4'b1111 when en=0, when the current digit is blanked, or when resetn=0; otherwise an SHALL be ~(4'b0001 << sel).
REQ-024 an and sel SHALL refer to the same digit in every cycle, with zero latency between them.
REQ-025 en falling mid-frame SHALL freeze sel and div_cnt; en rising SHALL resume counting from the held values without restarting the frame.
REQ-026 A pending commit SHALL wait while en=0, since no frame boundary can occur while en=0.

Reset
REQ-027 While resetn=0, the block SHALL force div_cnt=0, sel=00, disp_val=16'h0000, shadow=16'h0000, pending=0, frame_tick=0, and an=4'b1111, asynchronously.
REQ-028 Reset asserted mid-frame SHALL discard any staged value, and after release scanning SHALL restart at digit 0 with a full DIV_MAX+1 period.

Structure
REQ-029 A shared package scan_pkg SHALL hold NUM_DIGITS=4, NIBBLE_W=4, and AN_OFF=4'b1111.
REQ-030 The prescaler SHALL be a sub-module tick_gen with ports clk, resetn, en, and tick, parameterised by DIV_MAX and DIV_WIDTH.
REQ-031 The digit counter, shadow/commit logic and anode decode SHALL reside in scan_ctrl.

Verification (bench uses DIV_MAX=3)
REQ-032 Reset release with en=1 and disp_val=0 -> sel SHALL step 00,01,10,11 every 4 clocks, an SHALL step 1110,1101,1011,0111, and frame_tick SHALL pulse every 16 clocks.
REQ-033 load with din=16'h1234 mid-frame -> pending=1 and disp_val SHALL stay 16'h0000 until the next frame_tick, then become 16'h1234 with pending=0.
REQ-034 load 16'hAAAA then load 16'h5555 before the boundary -> disp_val SHALL become 16'h5555 at the boundary.
REQ-035 load with din=16'hBEEF in the exact frame_tick cycle -> disp_val SHALL become 16'hBEEF on that edge and pending SHALL remain 0.
REQ-036 blank_lz=1 with disp_val=16'h0070 -> an SHALL be 1111 for sel=11 and sel=10, 1101 for sel=01, and 1110 for sel=00.
REQ-037 en=0 for 10 clocks at sel=10 -> an=1111 and sel and div_cnt SHALL hold; after en=1, sel SHALL advance after the remaining count. Then resetn=0 mid-scan -> all outputs SHALL take their reset values immediately.
